// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, the EBREAK encoding and the fetch FSM state type.
package ifetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] EBREAK_INSTR = 32'h00100073;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: fetch buffer with flush; a push is accepted on full when a pop happens in the same cycle.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign empty = r_cnt == '0;
    assign full = r_cnt == L_FULL;
    assign w_pop = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout = r_mem[r_rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing into a fetch buffer with EBREAK halt and redirect flush.
// IFETCH_MISALIGN_TRAP_EN: a misaligned redirect target traps to FAULT instead of being aligned down.
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [XLEN-1:0] imem_pc,
    input  logic [ILEN-1:0] imem_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);
    state_t r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0] r_count;
    logic w_full, w_empty, w_deq, w_redir, w_fetch;
    logic [ILEN+XLEN-1:0] w_head;
    assign w_deq = !w_empty && out_ready;
    assign w_redir = redirect_valid && (r_state == S_RUN || r_state == S_HALTED);
    assign w_fetch = r_state == S_RUN && !w_redir && (!w_full || w_deq);
    ifetch_fifo #(.DEPTH(BUF_DEPTH), .W(ILEN + XLEN)) u_fifo (
        .clk(clk), .rst(rst), .push(w_fetch), .pop(w_deq), .flush(w_redir),
        .din({imem_instr, r_pc}), .dout(w_head), .full(w_full), .empty(w_empty)
    );
    assign imem_pc = r_pc;
    assign out_valid = !w_empty;
    assign out_instr = w_empty ? '0 : w_head[XLEN +: ILEN];
    assign out_pc = w_empty ? '0 : w_head[XLEN-1:0];
    assign halted = r_state == S_HALTED;
    assign fetch_count = r_count;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic w_trap;
    assign w_trap = redirect_pc[1:0] != 2'b00;
    assign fault = r_state == S_FAULT;
`else
    assign fault = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc <= RESET_PC;
            r_count <= '0;
        end else begin
            if (w_fetch) r_count <= r_count + 32'd1;
            if (r_state == S_IDLE) begin
                r_state <= start ? S_RUN : S_IDLE;
            end else if (w_redir) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (w_trap) begin
                    r_state <= S_FAULT;
                end else begin
                    r_state <= S_RUN;
                    r_pc <= redirect_pc;
                end
`else
                r_state <= S_RUN;
                r_pc <= redirect_pc & ~64'h3;
`endif
            end else if (w_fetch) begin
                r_pc <= r_pc + 64'd4;
                if (imem_instr == EBREAK_INSTR) r_state <= S_HALTED;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: queue-based reference model feeding a scoreboard checked by a negedge monitor.
module tb_instruction_fetch_unit;
    localparam int DEPTH = 2;
    logic clk = 0, rst = 0, start = 0, out_ready = 0, redirect_valid = 0;
    logic [63:0] redirect_pc = '0, imem_pc, out_pc;
    logic [31:0] imem_instr, out_instr, fetch_count;
    logic out_valid, halted, fault;
    logic [31:0] mem [256];
    assign imem_instr = mem[imem_pc[9:2]];

    instruction_fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
        .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    typedef struct packed {logic [31:0] instr; logic [63:0] pc;} ent_t;
    ent_t sb[$];
    ent_t e;
    typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mst_t;
    mst_t m_state = M_IDLE;
    logic [63:0] m_pc = '0;
    logic [31:0] m_cnt = '0;
    bit mon_en = 0;

    task chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // The scoreboard holds exactly what the buffer should hold; a handshake retires its head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", out_valid, sb.size() != 0);
            chk("imem_pc", imem_pc, m_pc);
            chk("halted", halted, m_state == M_HALT);
            chk("fault", fault, m_state == M_FAULT);
            chk("fetch_count", fetch_count, m_cnt);
            if (out_valid && sb.size() != 0) begin
                e = sb[0];
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task step(bit s, bit r, logic [63:0] rpc, bit rdy);
        bit hs, redir, fetch;
        logic [31:0] ins;
        start = s; redirect_valid = r; redirect_pc = rpc; out_ready = rdy;
        hs = rdy && sb.size() != 0;
        redir = r && (m_state == M_RUN || m_state == M_HALT);
        fetch = m_state == M_RUN && !redir && (sb.size() < DEPTH || hs);
        ins = mem[m_pc[9:2]];
        @(posedge clk);
        #1;
        if (m_state == M_IDLE) begin
            if (s) m_state = M_RUN;
        end else if (redir) begin
            sb.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) m_state = M_FAULT;
            else begin m_state = M_RUN; m_pc = rpc; end
`else
            m_state = M_RUN;
            m_pc = {rpc[63:2], 2'b00};
`endif
        end else if (fetch) begin
            sb.push_back(ent_t'{instr: ins, pc: m_pc});
            m_cnt++;
            m_pc += 64'd4;
            if (ins == 32'h00100073) m_state = M_HALT;
        end
    endtask

    task do_reset;
        #2 rst = 1;
        start = 0; redirect_valid = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_imem_pc", imem_pc, 0);
        sb.delete(); m_state = M_IDLE; m_pc = '0; m_cnt = '0;
        @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
    endtask

    task fill_mem(int ebreak_pct);
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'h00100073) mem[i] = 32'h00000013;
            if ($urandom_range(0, 99) < ebreak_pct) mem[i] = 32'h00100073;
        end
        mem[0] = 32'h00106433; mem[1] = 32'h0020e4b3; mem[2] = 32'h0020f533;
    endtask

    initial begin
        fill_mem(0);
        mem[3] = 32'h00100073;
        do_reset();
        // start, stream three ALU ops, then EBREAK halts with PC parked at 16
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        chk("halt_flag", halted, 1);
        chk("halt_imem_pc", imem_pc, 64'h10);
        chk("halt_count", fetch_count, 4);
        // stalled consumer: buffer fills at two entries
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("stall_count", fetch_count, 2);
        chk("stall_imem_pc", imem_pc, 64'h8);
        chk("stall_out_pc", out_pc, 64'h0);
        // redirect with head accepted in the same cycle
        step(0, 1, 64'h40, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("redir_halted", halted, 0);
        // misaligned redirect target
        step(0, 0, 0, 0);
        step(0, 1, 64'h42, 1);
        step(0, 0, 0, 1);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("mis_fault", fault, 1);
        chk("mis_out_valid", out_valid, 0);
`else
        chk("mis_fault", fault, 0);
`endif
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        // reset mid-stream with a full buffer, then no fetch until start
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 64'h80, 1);
        chk("idle_count", fetch_count, 0);
        chk("idle_imem_pc", imem_pc, 0);
        step(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        // randomized traffic
        fill_mem(4);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_state == M_FAULT || $urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 64'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 Parameter: BUF_DEPTH, 2, fetch buffer entries (power of two, >=2).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 Port: start  input  1  leave IDLE and begin fetching.
REQ-006 Port: imem_pc  output  64  byte address driven to instruction_memory pc.
REQ-007 Port: imem_instr  input  32  combinational instruction_memory instr for imem_pc, same cycle.
REQ-008 Port: out_valid  output  1  buffer head valid.
REQ-009 Port: out_ready  input  1  consumer accepts head.
REQ-010 Port: out_instr  output  32  head instruction.
REQ-011 Port: out_pc  output  64  head instruction address.
REQ-012 Port: redirect_valid  input  1  branch/jump redirect request.
REQ-013 Port: redirect_pc  input  64  redirect target.
REQ-014 Port: halted  output  1  high in HALTED state.
REQ-015 Port: fault  output  1  high in FAULT state.
REQ-016 Port: fetch_count  output  32  instructions enqueued since reset, wraps at 2^32.

Function
REQ-017 FSM states IDLE, RUN, HALTED, FAULT; reset state IDLE.
REQ-018 IDLE->RUN when start=1; start ignored in other states.
REQ-019 imem_pc always equals the internal PC register.
REQ-020 Fetch occurs in a RUN cycle when buffer not full, or full with out_valid&&out_ready that cycle; fetch enqueues {imem_instr, PC} at the edge and PC<=PC+4 (64-bit wrap).
REQ-021 Enqueue-to-visibility latency one cycle: entry fetched at edge N is on out_* after edge N.
REQ-022 Handshake: dequeue on out_valid&&out_ready; out_instr/out_pc stable while out_valid&&!out_ready; out_valid=buffer non-empty.
REQ-023 Fetching instruction 32'h00100073 (EBREAK) enqueues it, increments fetch_count, enters HALTED; no fetch in HALTED; buffer drains normally.
REQ-024 redirect_valid (any state except IDLE and FAULT): flush buffer, PC<=redirect_pc, no enqueue that cycle, state->RUN; redirect wins over fetch and EBREAK detection.
REQ-025 Dequeue and redirect in same cycle: handshake counts as accepted, then flush.
REQ-026 redirect_valid in IDLE ignored.
REQ-027 fetch_count increments by 1 per enqueue only.

Reset
REQ-028 rst asserted at any time, mid-fetch included: state IDLE, PC=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, fetch_count=0, asynchronously.
REQ-029 First fetch no earlier than the first edge where state is RUN after rst deasserts.

Configuration
REQ-030 Macro IFETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 flushes buffer, enters FAULT, fault=1; FAULT exits only by rst.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 0 before loading PC, FAULT unreachable, fault tied 0.

Structure
REQ-032 Package ifetch_pkg holds XLEN=64, ILEN=32, EBREAK_INSTR constant, state enum type.
REQ-033 Sub-module ifetch_fifo (BUF_DEPTH entries, push/pop/flush, full/empty, simultaneous push+pop on full allowed) holds the buffer.

Verification
REQ-034 Reset, start=1 one cycle, out_ready=1, memory 0x00106433,0x0020e4b3,0x0020f533 -> out_pc 0,4,8 on consecutive cycles with matching out_instr.
REQ-035 out_ready=0 for 5 cycles after start -> buffer fills at 2, imem_pc holds 8, out_pc stays 0, fetch_count=2.
REQ-036 im[3]=0x00100073, out_ready=1 -> PC 12 delivered, halted=1 next cycle, imem_pc stays 16, fetch_count=4.
REQ-037 redirect_valid with redirect_pc=0x40 while buffer holds 2 entries and out_ready=1 -> head accepted, buffer flushed, next out_pc=0x40, halted=0.
REQ-038 redirect_pc=0x42: with IFETCH_MISALIGN_TRAP_EN fault=1 and out_valid=0; without it next out_pc=0x40.
REQ-039 rst pulse mid-stream with full buffer -> all outputs reset values immediately, imem_pc=RESET_PC, no fetch until start.
